// File: rtl/instr_prefetch_queue.sv
// instr_prefetch_queue: sequential instruction prefetch buffer with redirect flush.
// Optional macro PREFETCH_BYPASS_EN forwards a response straight to the head when empty.
module instr_prefetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [31:0] instr_pc4,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1) + 1;
  localparam int OW = CW + 2;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [31:0]   qInstr [DEPTH];
  logic [31:0]   qPc    [DEPTH];
  logic [PW-1:0] rdPtr;
  logic [PW-1:0] wrPtr;
  logic [CW-1:0] count;
  logic [CW-1:0] liveCnt;
  logic [CW-1:0] dropCnt;
  logic [OW-1:0] occ;
  logic [31:0]   reqAddr;
  logic [31:0]   addrHold;
  logic [31:0]   pcTrk;
  logic [31:0]   redirAddr;
  logic          reqPend;
  logic          staleReq;
  logic          gnt;
  logic          rspKeep;
  logic          rspDrop;
  logic          push;
  logic          pop;
  logic          bypass;
  logic          empty;

  // Request issue, response classification and head presentation.
  always_comb begin
    redirAddr = redirect_pc & ~32'h3;
    empty     = (count == '0);
    occ       = OW'(count) + OW'(liveCnt) + OW'(dropCnt);
    mem_req   = !rst && (reqPend || (occ < OW'(DEPTH)));
    mem_addr  = reqPend ? addrHold : reqAddr;
    gnt       = mem_req && mem_gnt;
    rspDrop   = mem_rvalid && (dropCnt != '0);
    rspKeep   = mem_rvalid && (dropCnt == '0);
    bypass    = 1'b0;
`ifdef PREFETCH_BYPASS_EN
    bypass    = empty && rspKeep && !redirect && !rst;
`endif
    instr_valid = !empty || bypass;
    instr       = bypass ? mem_rdata : qInstr[rdPtr];
    instr_pc    = bypass ? pcTrk : qPc[rdPtr];
    instr_pc4   = instr_pc + 32'd4;
    pop  = !empty && !stall && !redirect;
    push = rspKeep && !redirect && !(bypass && !stall);
  end

  // In-order instruction queue storage and pointers.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        qInstr[i] <= NOP;
        qPc[i]    <= RESET_PC;
      end
    end else if (redirect) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else begin
      if (push) begin
        qInstr[wrPtr] <= mem_rdata;
        qPc[wrPtr]    <= pcTrk;
        wrPtr         <= wrPtr + PW'(1);
      end
      if (pop) begin
        rdPtr <= rdPtr + PW'(1);
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Outstanding-request bookkeeping, fetch address and PC tracker.
  always_ff @(posedge clk) begin
    if (rst) begin
      liveCnt  <= '0;
      dropCnt  <= '0;
      staleReq <= 1'b0;
      reqPend  <= 1'b0;
      reqAddr  <= RESET_PC;
      addrHold <= RESET_PC;
      pcTrk    <= RESET_PC;
    end else begin
      reqPend  <= mem_req && !mem_gnt;
      addrHold <= mem_addr;
      if (redirect) begin
        liveCnt  <= '0;
        dropCnt  <= liveCnt + dropCnt + CW'(gnt) - CW'(mem_rvalid);
        staleReq <= mem_req && !mem_gnt;
        reqAddr  <= redirAddr;
        pcTrk    <= redirAddr;
      end else begin
        liveCnt <= liveCnt + CW'(gnt && !staleReq) - CW'(rspKeep);
        dropCnt <= dropCnt + CW'(gnt && staleReq) - CW'(rspDrop);
        if (gnt) begin
          staleReq <= 1'b0;
        end
        if (gnt && !staleReq) begin
          reqAddr <= reqAddr + 32'd4;
        end
        if (rspKeep) begin
          pcTrk <= pcTrk + 32'd4;
        end
      end
    end
  end

endmodule

// File: tb/tb_instr_prefetch_queue.sv
// tb_instr_prefetch_queue: directed bench for instr_prefetch_queue.
// Memory model: grant under bench control, in-order response one cycle after grant.
module tb_instr_prefetch_queue;

`ifdef PREFETCH_BYPASS_EN
  localparam int LAT = 0;
`else
  localparam int LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        stall;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [31:0] instr_pc4;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  int          checks = 0;
  int          errors = 0;
  int          gntCount = 0;
  logic        respEn;
  logic [31:0] memQ[$];
  logic [31:0] grantLog[$];

  instr_prefetch_queue #(.DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .stall(stall),
    .instr_valid(instr_valid), .instr(instr),
    .instr_pc(instr_pc), .instr_pc4(instr_pc4),
    .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic driveMem();
    mem_rvalid = respEn && (memQ.size() > 0);
    mem_rdata  = (memQ.size() > 0) ? ~memQ[0] : 32'h0;
  endtask

  task automatic tick();
    logic        g;
    logic        r;
    logic [31:0] a;
    driveMem();
    #1;
    g = mem_req && mem_gnt;
    a = mem_addr;
    r = mem_rvalid;
    if (g && !rst) begin
      grantLog.push_back(a);
      gntCount++;
    end
    @(posedge clk);
    #1;
    if (rst) begin
      memQ.delete();
    end else begin
      if (r) void'(memQ.pop_front());
      if (g) memQ.push_back(a);
    end
    driveMem();
    #1;
  endtask

  task automatic doReset();
    rst = 1'b1; redirect = 1'b0; stall = 1'b0;
    mem_gnt = 1'b1; respEn = 1'b1;
    tick(); tick();
    memQ.delete(); grantLog.delete(); gntCount = 0;
    rst = 1'b0;
    driveMem();
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; redirect = 1'b0; redirect_pc = '0; stall = 1'b0;
    mem_gnt = 1'b1; respEn = 1'b1;
    tick(); tick();
    checks++;
    if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", instr_valid); end
    checks++;
    if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_req got %b want 0", mem_req); end
    checks++;
    if (instr !== 32'h13) begin errors++; $display("FAIL reset_instr got %h want 00000013", instr); end
    checks++;
    if (instr_pc !== 32'h0) begin errors++; $display("FAIL reset_pc got %h want 0", instr_pc); end
    checks++;
    if (instr_pc4 !== 32'h4) begin errors++; $display("FAIL reset_pc4 got %h want 4", instr_pc4); end
    checks++;
    if (mem_addr !== 32'h0) begin errors++; $display("FAIL reset_addr got %h want 0", mem_addr); end
    rst = 1'b0;
    grantLog.delete(); gntCount = 0;
    #1;
    checks++;
    if (mem_req !== 1'b1) begin errors++; $display("FAIL first_req got %b want 1", mem_req); end
  endtask

  task automatic test_stream();
    logic        expValid;
    logic [31:0] expPc;
    for (int k = 1; k <= 6; k++) begin
      tick();
      expValid = (k >= 1 + LAT);
      expPc    = 32'(4 * (k - 1 - LAT));
      checks++;
      if (instr_valid !== expValid) begin
        errors++; $display("FAIL stream_valid k=%0d got %b want %b", k, instr_valid, expValid);
      end
      if (expValid) begin
        checks++;
        if (instr_pc !== expPc || instr_pc4 !== expPc + 32'd4 || instr !== ~expPc) begin
          errors++;
          $display("FAIL stream_head k=%0d got pc=%h pc4=%h ins=%h want pc=%h", k, instr_pc, instr_pc4, instr, expPc);
        end
      end
    end
    checks++;
    if (grantLog.size() < 6) begin
      errors++; $display("FAIL stream_grants got %0d want 6", grantLog.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (grantLog[i] !== 32'(4 * i)) begin
          errors++; $display("FAIL stream_addr i=%0d got %h want %h", i, grantLog[i], 32'(4 * i));
        end
      end
    end
  endtask

  task automatic test_backpressure();
    doReset();
    stall = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    checks++;
    if (gntCount !== 4) begin errors++; $display("FAIL bp_grants got %0d want 4", gntCount); end
    checks++;
    if (mem_req !== 1'b0) begin errors++; $display("FAIL bp_req got %b want 0", mem_req); end
    checks++;
    if (instr_valid !== 1'b1 || instr_pc !== 32'h0) begin
      errors++; $display("FAIL bp_head got v=%b pc=%h want v=1 pc=0", instr_valid, instr_pc);
    end
    stall = 1'b0;
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (instr_valid !== 1'b1 || instr_pc !== 32'(4 * i)) begin
        errors++; $display("FAIL bp_pop i=%0d got v=%b pc=%h want %h", i, instr_valid, instr_pc, 32'(4 * i));
      end
      tick();
      if (i == 0) begin
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h10) begin
          errors++; $display("FAIL bp_resume got req=%b addr=%h want 1 00000010", mem_req, mem_addr);
        end
      end
    end
  endtask

  task automatic test_redirect_inflight();
    logic found;
    doReset();
    respEn = 1'b0;
    tick(); tick();
    redirect = 1'b1; redirect_pc = 32'h100;
    tick();
    redirect = 1'b0; respEn = 1'b1;
    driveMem();
    #1;
    checks++;
    if (instr_valid !== 1'b0) begin errors++; $display("FAIL rdi_valid got %b want 0", instr_valid); end
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h100) begin
      errors++; $display("FAIL rdi_addr got req=%b addr=%h want 1 00000100", mem_req, mem_addr);
    end
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      found = instr_valid;
    end
    checks++;
    if (!found || instr_pc !== 32'h100 || instr !== ~32'h100) begin
      errors++; $display("FAIL rdi_first got v=%b pc=%h ins=%h want pc=00000100", found, instr_pc, instr);
    end
    tick();
    checks++;
    if (instr_valid !== 1'b1 || instr_pc !== 32'h104) begin
      errors++; $display("FAIL rdi_next got v=%b pc=%h want 00000104", instr_valid, instr_pc);
    end
  endtask

  task automatic test_redirect_pending();
    logic found;
    int   n;
    doReset();
    for (int i = 0; i < 8; i++) tick();
    mem_gnt = 1'b0;
    tick();
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h20) begin
      errors++; $display("FAIL rdp_pend got req=%b addr=%h want 1 00000020", mem_req, mem_addr);
    end
    redirect = 1'b1; redirect_pc = 32'h203;
    tick();
    redirect = 1'b0;
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h20 || instr_valid !== 1'b0) begin
      errors++; $display("FAIL rdp_hold got req=%b addr=%h v=%b want 1 00000020 0", mem_req, mem_addr, instr_valid);
    end
    tick(); tick();
    checks++;
    if (mem_addr !== 32'h20) begin errors++; $display("FAIL rdp_hold2 got %h want 00000020", mem_addr); end
    n = grantLog.size();
    mem_gnt = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      found = instr_valid;
    end
    checks++;
    if (!found || instr_pc !== 32'h200 || instr !== ~32'h200) begin
      errors++; $display("FAIL rdp_first got v=%b pc=%h ins=%h want pc=00000200", found, instr_pc, instr);
    end
    checks++;
    if (grantLog.size() < n + 2 || grantLog[n] !== 32'h20 || grantLog[n+1] !== 32'h200) begin
      errors++; $display("FAIL rdp_grants got n=%0d size=%0d want 00000020 then 00000200", n, grantLog.size());
    end
  endtask

  task automatic test_wrap();
    logic found;
    int   n;
    doReset();
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFF8;
    tick();
    redirect = 1'b0;
    n = grantLog.size();
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      found = instr_valid;
    end
    checks++;
    if (!found || instr_pc !== 32'hFFFF_FFF8) begin
      errors++; $display("FAIL wrap_first got v=%b pc=%h want fffffff8", found, instr_pc);
    end
    tick();
    checks++;
    if (instr_valid !== 1'b1 || instr_pc !== 32'hFFFF_FFFC || instr_pc4 !== 32'h0) begin
      errors++; $display("FAIL wrap_second got v=%b pc=%h pc4=%h want fffffffc 0", instr_valid, instr_pc, instr_pc4);
    end
    tick();
    checks++;
    if (instr_valid !== 1'b1 || instr_pc !== 32'h0) begin
      errors++; $display("FAIL wrap_third got v=%b pc=%h want 0", instr_valid, instr_pc);
    end
    checks++;
    if (grantLog.size() < n + 3 || grantLog[n] !== 32'hFFFF_FFF8 || grantLog[n+1] !== 32'hFFFF_FFFC || grantLog[n+2] !== 32'h0) begin
      errors++; $display("FAIL wrap_grants got size=%0d from %0d want fffffff8 fffffffc 0", grantLog.size(), n);
    end
  endtask

  task automatic test_midreset();
    rst = 1'b1;
    #1;
    checks++;
    if (mem_req !== 1'b0) begin errors++; $display("FAIL mrst_req got %b want 0", mem_req); end
    tick();
    checks++;
    if (instr_valid !== 1'b0 || instr !== 32'h13) begin
      errors++; $display("FAIL mrst_head got v=%b ins=%h want 0 00000013", instr_valid, instr);
    end
    checks++;
    if (instr_pc !== 32'h0 || instr_pc4 !== 32'h4 || mem_addr !== 32'h0) begin
      errors++; $display("FAIL mrst_pc got pc=%h pc4=%h addr=%h want 0 4 0", instr_pc, instr_pc4, mem_addr);
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; redirect = 1'b0; redirect_pc = '0; stall = 1'b0;
    mem_gnt = 1'b0; respEn = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_inflight();
    test_redirect_pending();
    test_wrap();
    test_midreset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
